// File: rtl/mips_pkg.sv
// mips_pkg: arbiter state encoding and word-alignment constant shared by the memory arbiter files
package mips_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;
  localparam logic [1:0] WORD_ALIGN = 2'b00;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational two-way picker; on a tie the requester not granted last wins
module arb_pick (
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       last_d_i,
  output logic [1:0] gnt_o
);
  assign gnt_o = (d_req_i && (!i_req_i || !last_d_i)) ? 2'b10 : i_req_i ? 2'b01 : 2'b00;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction-fetch and data requesters.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise data always beats instruction.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);
  state_t state_q, state_d;
  logic acked_q, acked_d;
  logic sel_d_q;
  logic last_d;
  logic [1:0] gnt;
  logic grant_go, ack_go, in_grant;
  logic [AW-1:0] addr_q;
  logic we_q;
  logic [3:0] be_q;
  logic [DW-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};
`ifdef MEM_ARB_RR_EN
  assign last_d = sel_d_q;
`else
  assign last_d = 1'b0;
`endif
  arb_pick u_pick (
    .i_req_i (i_req),
    .d_req_i (d_req),
    .last_d_i(last_d),
    .gnt_o   (gnt)
  );
  assign in_grant = state_q == GRANT_I || state_q == GRANT_D;
  assign grant_go = state_q == IDLE && |gnt;
  assign ack_go   = in_grant && !acked_q && m_ack;
  // The ack is registered for one cycle before RESP, so m_req spans the ack cycle too.
  always_comb begin
    state_d = state_q;
    acked_d = 1'b0;
    case (state_q)
      IDLE:             state_d = gnt[1] ? GRANT_D : gnt[0] ? GRANT_I : IDLE;
      GRANT_I, GRANT_D: begin
        state_d = acked_q ? RESP : state_q;
        acked_d = !acked_q && m_ack;
      end
      default:          state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acked_q   <= 1'b0;
      sel_d_q   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      acked_q <= acked_d;
      if (grant_go) begin
        sel_d_q <= gnt[1];
        addr_q  <= {gnt[1] ? d_addr[AW-1:2] : i_addr[AW-1:2], WORD_ALIGN};
        we_q    <= gnt[1] && d_we;
        be_q    <= gnt[1] ? d_be : 4'hF;
        wdata_q <= gnt[1] ? d_wdata : '0;
      end
      if (ack_go && sel_d_q) d_rdata_q <= m_rdata;
      if (ack_go && !sel_d_q) i_rdata_q <= m_rdata;
    end
  end
  assign m_req   = in_grant;
  assign m_we    = we_q;
  assign m_be    = be_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_ready = state_q == RESP && !sel_d_q;
  assign d_ready = state_q == RESP && sel_d_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = state_q != IDLE;
endmodule
